// File: rtl/universal_shift_reg_pkg.sv
// Shared mode encodings for the universal shift register and its users.
package shift_reg_defs;

    localparam int unsigned MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_HOLD  = 3'b000;
    localparam logic [MODE_W-1:0] MODE_SHL   = 3'b001;
    localparam logic [MODE_W-1:0] MODE_SHR   = 3'b010;
    localparam logic [MODE_W-1:0] MODE_ROL   = 3'b011;
    localparam logic [MODE_W-1:0] MODE_ROR   = 3'b100;
    localparam logic [MODE_W-1:0] MODE_LOAD  = 3'b101;
    localparam logic [MODE_W-1:0] MODE_CLEAR = 3'b110;

endpackage

// File: rtl/shift_bit_counter.sv
// Saturating count of valid serial bits; full is derived from the next-state count.
module shift_bit_counter #(
    parameter int unsigned MAX = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         inc,
    input  logic                         set_max,
    input  logic                         clr,
    output logic [$clog2(MAX+1)-1:0]     count,
    output logic                         full
);

    localparam int unsigned CNT_W = $clog2(MAX + 1);

    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (set_max) begin
            count_d = CNT_W'(MAX);
        end else if (inc && (count_q != CNT_W'(MAX))) begin
            count_d = count_q + CNT_W'(1);
        end
        full_d = (count_d == CNT_W'(MAX));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

    assign count = count_q;
    assign full  = full_q;

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold/shift/rotate/load/clear per cycle, with fill tracking.
module universal_shift_reg
    import shift_reg_defs::*;
#(
    parameter int unsigned       WIDTH       = 4,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [MODE_W-1:0]            mode,
    input  logic                         ser_in_l,
    input  logic                         ser_in_r,
    input  logic [WIDTH-1:0]             par_in,
    output logic [WIDTH-1:0]             out,
    output logic                         ser_out_l,
    output logic                         ser_out_r,
    output logic [$clog2(WIDTH+1)-1:0]   count,
    output logic                         full
);

    logic [WIDTH-1:0] out_q, out_d;
    logic             cnt_inc, cnt_set_max, cnt_clr;

    // Data path and counter controls; reserved mode falls through as hold.
    always_comb begin
        out_d       = out_q;
        cnt_inc     = 1'b0;
        cnt_set_max = 1'b0;
        cnt_clr     = 1'b0;
        if (en) begin
            case (mode)
                MODE_SHL: begin
                    out_d   = {out_q[WIDTH-2:0], ser_in_l};
                    cnt_inc = 1'b1;
                end
                MODE_SHR: begin
                    out_d   = {ser_in_r, out_q[WIDTH-1:1]};
                    cnt_inc = 1'b1;
                end
                MODE_ROL: out_d = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
                MODE_ROR: out_d = {out_q[0], out_q[WIDTH-1:1]};
                MODE_LOAD: begin
                    out_d       = par_in;
                    cnt_set_max = 1'b1;
                end
                MODE_CLEAR: begin
                    out_d   = RESET_VALUE;
                    cnt_clr = 1'b1;
                end
                default: out_d = out_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= RESET_VALUE;
        end else begin
            out_q <= out_d;
        end
    end

    shift_bit_counter #(
        .MAX (WIDTH)
    ) u_counter (
        .clk     (clk),
        .rst     (rst),
        .inc     (cnt_inc),
        .set_max (cnt_set_max),
        .clr     (cnt_clr),
        .count   (count),
        .full    (full)
    );

    assign out       = out_q;
    assign ser_out_l = out_q[WIDTH-1];
    assign ser_out_r = out_q[0];

endmodule

// File: doc/universal_shift_reg.md
Name: universal_shift_reg

Overview:
Parametrised universal shift register, generalising the lab's fixed 4-bit shift-left register.
- Supports hold, shift left/right, rotate left/right, parallel load and clear, selected per cycle by a mode input with a global enable.
- Tracks how many valid serial bits have been shifted in since the last load, clear or reset, and flags when the register is full.
- Sits between serial links and parallel datapaths as serializer, deserializer or rotator.

Parameters:
- WIDTH, 4, register width in bits; legal range 2..32.
- RESET_VALUE, 0, value of out after reset and after CLEAR (WIDTH bits).

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  synchronous, active-high reset.
- en  input  1  1 = execute mode this edge; 0 = hold all state.
- mode  input  3  operation select; encodings under Behaviour.
- ser_in_l  input  1  bit entering at out[0] on SHL.
- ser_in_r  input  1  bit entering at out[WIDTH-1] on SHR.
- par_in  input  WIDTH  parallel load data.
- out  output  WIDTH  register contents (registered).
- ser_out_l  output  1  out[WIDTH-1], the bit leaving on the next SHL (combinational from out).
- ser_out_r  output  1  out[0], the bit leaving on the next SHR (combinational from out).
- count  output  $clog2(WIDTH+1)  number of valid bits shifted in; saturates at WIDTH (registered).
- full  output  1  1 when count == WIDTH (registered, same edge as count).

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. rst has priority over en and mode.
- On the reset edge: out = RESET_VALUE, count = 0, full = 0.
- All updates happen on the rising clk edge with en=1 and are visible immediately after that edge (1-cycle latency). No combinational path from inputs to out, count or full.
- en=0: out, count and full hold, regardless of mode.
- Mode encodings, when en=1:
  - 000 HOLD: out, count and full unchanged.
  - 001 SHL: out = {out[WIDTH-2:0], ser_in_l}; count = min(count+1, WIDTH).
  - 010 SHR: out = {ser_in_r, out[WIDTH-1:1]}; count = min(count+1, WIDTH).
  - 011 ROL: out = {out[WIDTH-2:0], out[WIDTH-1]}; count unchanged.
  - 100 ROR: out = {out[0], out[WIDTH-1:1]}; count unchanged.
  - 101 LOAD: out = par_in; count = WIDTH.
  - 110 CLEAR: out = RESET_VALUE; count = 0.
  - 111 reserved: treated as HOLD, no state change.
- full is recomputed from the next-state count, so it rises on the same edge that count reaches WIDTH.
- Saturation: once count == WIDTH, further shifts still move data (oldest bit is lost via ser_out_l or ser_out_r) but count stays WIDTH and full stays 1.
- Direction changes (SHL followed by SHR) are legal; count keeps incrementing; no direction tracking.
- Reset mid-operation, i.e. rst asserted during a shift sequence: the next edge gives the reset state; the partial sequence is discarded.
- ser_out_l and ser_out_r reflect current out, so a consumer samples the outgoing bit before the edge that shifts it out.

Decomposition:
- Shared header/package shift_reg_defs: mode localparams MODE_HOLD, MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_LOAD, MODE_CLEAR (3-bit). Used by RTL and bench.
- One natural sub-module: shift_bit_counter.
  - Parameter MAX = WIDTH.
  - Inputs: inc, set_max, clr.
  - Outputs: count, full.
  - Saturating counter with synchronous reset.
- The data path stays in universal_shift_reg as a single case on mode.

Test Plan:
- Reset: rst=1 for 2 cycles with mode=LOAD, par_in=1111 (WIDTH=4) -> out=0000, count=0, full=0; rst wins over LOAD.
- SHL fill: SHL with ser_in_l = 1,0,1,0 -> out = 0001, 0010, 0101, 1010; count = 1, 2, 3, 4; full=1 after 4th edge. 5th SHL, ser_in_l=1: ser_out_l=1 before edge, out=0101 after, count stays 4.
- Load/rotate: LOAD par_in=1001 -> out=1001, count=4, full=1. ROL -> 0011. ROR -> 1001. ROR -> 1100. count stays 4 throughout.
- CLEAR then SHR: CLEAR -> out=0000, count=0, full=0. SHR with ser_in_r=1 twice -> out 1000, then 1100; count=2; ser_out_r=0 throughout.
- Enable/reserved: en=0 with mode=SHL for 3 cycles -> out and count unchanged. en=1 with mode=111 -> unchanged.
- Mid-op reset and width: after 2 SHLs (count=2), rst=1 -> out=0000, count=0. WIDTH=8 instance: 8 SHLs of 1 -> out=11111111, count=8, full=1 on 8th edge.
